// File: rtl/tc08_pkg.sv
// Shared constants and types for the TC08 read path: mark codes, frame geometry,
// line-decoder state encoding and the decoder debug view.
package tc08_pkg;

  localparam int FRAME_LINES   = 6;
  localparam int BITS_PER_LINE = 3;
  localparam int MARK_W        = FRAME_LINES;
  localparam int DATA_W        = FRAME_LINES * BITS_PER_LINE;
  localparam int LC_W          = 3;
  localparam int WD_W          = 22;

  localparam logic [MARK_W-1:0] MK_SYNC  = 6'o25;
  localparam logic [MARK_W-1:0] MK_BLOCK = 6'o26;
  localparam logic [MARK_W-1:0] MK_GUARD = 6'o32;
  localparam logic [MARK_W-1:0] MK_LOCK  = 6'o10;
  localparam logic [MARK_W-1:0] MK_DATA  = 6'o70;
  localparam logic [MARK_W-1:0] MK_FINAL = 6'o73;
  localparam logic [MARK_W-1:0] MK_END   = 6'o22;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } tc08_state_e;

  typedef struct packed {
    tc08_state_e       state;
    logic [LC_W-1:0]   lc;
  } tc08_dbg_t;

  // Mark windows the TC08 accepts at a frame boundary once aligned.
  function automatic logic mk_is_valid(input logic [MARK_W-1:0] mk);
    case (mk)
      MK_SYNC, MK_BLOCK, MK_GUARD, MK_LOCK,
      MK_DATA, MK_FINAL, MK_END: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tc08_diff_sync.sv
// Synchroniser for one differential head pair: both phases pass through STAGES flops,
// the pair is valid only when the synced phases differ.
module tc08_diff_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic pos,
  input  logic neg,
  output logic pos_s,
  output logic valid
);

  logic [STAGES-1:0] pos_q;
  logic [STAGES-1:0] neg_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pos_q <= '0;
      neg_q <= '0;
    end else begin
      pos_q <= {pos_q[STAGES-2:0], pos};
      neg_q <= {neg_q[STAGES-2:0], neg};
    end
  end

  assign pos_s = pos_q[STAGES-1];
  assign valid = pos_q[STAGES-1] ^ neg_q[STAGES-1];

endmodule

// File: rtl/tc08_line_decoder.sv
// TC08 receive line decoder: turns synced TU55 head pairs into line strobes and
// 6-line frames (18 data bits + 6-bit mark) with lock, mark-error and motion status.
module tc08_line_decoder
  import tc08_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2000000
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              t_trk_rd_pos,
  input  logic              t_trk_rd_neg,
  input  logic              rdmk_rd_pos,
  input  logic              rdmk_rd_neg,
  input  logic              rdd_00_rd_pos,
  input  logic              rdd_00_rd_neg,
  input  logic              rdd_01_rd_pos,
  input  logic              rdd_01_rd_neg,
  input  logic              rdd_02_rd_pos,
  input  logic              rdd_02_rd_neg,
  output logic              line_strobe,
  output logic              frame_strobe,
  output logic [DATA_W-1:0] frame_data,
  output logic [MARK_W-1:0] frame_mark,
  output logic              locked,
  output logic              mark_err,
  output logic              moving,
  output tc08_dbg_t         dbg
);

  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(FRAME_LINES - 1);

  logic t_pos, t_vld;
  logic mk_pos, mk_vld;
  logic d0_pos, d0_vld;
  logic d1_pos, d1_vld;
  logic d2_pos, d2_vld;

  tc08_diff_sync #(.STAGES(SYNC_STAGES)) u_sync_t (
    .clk(clk), .rst_l(rst_l), .pos(t_trk_rd_pos), .neg(t_trk_rd_neg),
    .pos_s(t_pos), .valid(t_vld)
  );
  tc08_diff_sync #(.STAGES(SYNC_STAGES)) u_sync_mk (
    .clk(clk), .rst_l(rst_l), .pos(rdmk_rd_pos), .neg(rdmk_rd_neg),
    .pos_s(mk_pos), .valid(mk_vld)
  );
  tc08_diff_sync #(.STAGES(SYNC_STAGES)) u_sync_d0 (
    .clk(clk), .rst_l(rst_l), .pos(rdd_00_rd_pos), .neg(rdd_00_rd_neg),
    .pos_s(d0_pos), .valid(d0_vld)
  );
  tc08_diff_sync #(.STAGES(SYNC_STAGES)) u_sync_d1 (
    .clk(clk), .rst_l(rst_l), .pos(rdd_01_rd_pos), .neg(rdd_01_rd_neg),
    .pos_s(d1_pos), .valid(d1_vld)
  );
  tc08_diff_sync #(.STAGES(SYNC_STAGES)) u_sync_d2 (
    .clk(clk), .rst_l(rst_l), .pos(rdd_02_rd_pos), .neg(rdd_02_rd_neg),
    .pos_s(d2_pos), .valid(d2_vld)
  );

  tc08_state_e       state, state_nx;
  logic              t_pos_d;
  logic              line_ev;
  logic              wd_hit;
  logic [WD_W-1:0]   wd;
  logic [LC_W-1:0]   lc, lc_nx;
  logic [MARK_W-1:0] mark_sr, mark_sr_nx, mark_in;
  logic [DATA_W-1:0] data_sr, data_sr_nx, data_in;
  logic              fs_nx;
  logic              err_nx;

  // A line is sampled only when every track carries a live differential signal;
  // a dead track (both phases low) means the head is not over valid tape.
  assign line_ev = t_pos & ~t_pos_d & t_vld & mk_vld & d0_vld & d1_vld & d2_vld;
  assign wd_hit  = ~line_ev & (wd == WD_LAST);

  assign mark_in = {mark_sr[MARK_W-2:0], mk_pos};
  assign data_in = {data_sr[DATA_W-BITS_PER_LINE-1:0], d0_pos, d1_pos, d2_pos};

  always_comb begin
    state_nx   = state;
    lc_nx      = lc;
    err_nx     = mark_err;
    fs_nx      = 1'b0;
    mark_sr_nx = mark_sr;
    data_sr_nx = data_sr;
    if (line_ev) begin
      mark_sr_nx = mark_in;
      data_sr_nx = data_in;
    end
    unique case (state)
      ST_IDLE: begin
        if (line_ev) state_nx = ST_HUNT;
      end
      ST_HUNT: begin
        if (line_ev && (mark_in == MK_SYNC)) begin
          state_nx = ST_LOCKED;
          lc_nx    = '0;
          err_nx   = 1'b0;
          fs_nx    = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (line_ev) begin
          if (lc == LC_LAST) begin
            lc_nx = '0;
            if (mk_is_valid(mark_in)) begin
              fs_nx = 1'b1;
            end else begin
              err_nx   = 1'b1;
              state_nx = ST_HUNT;
            end
          end else begin
            lc_nx = lc + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Stalled tape: drop alignment and any half-assembled frame so the next
    // pass (possibly in the other direction) must re-acquire from scratch.
    if (wd_hit) begin
      state_nx   = ST_IDLE;
      lc_nx      = '0;
      mark_sr_nx = '0;
      data_sr_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      t_pos_d      <= 1'b0;
      wd           <= '0;
      lc           <= '0;
      mark_sr      <= '0;
      data_sr      <= '0;
      line_strobe  <= 1'b0;
      frame_strobe <= 1'b0;
      frame_data   <= '0;
      frame_mark   <= '0;
      mark_err     <= 1'b0;
    end else begin
      t_pos_d      <= t_pos;
      lc           <= lc_nx;
      mark_sr      <= mark_sr_nx;
      data_sr      <= data_sr_nx;
      line_strobe  <= line_ev;
      frame_strobe <= fs_nx;
      mark_err     <= err_nx;
      if (line_ev) begin
        wd <= '0;
      end else if (wd != WD_MAX) begin
        wd <= wd + 1'b1;
      end
      if (fs_nx) begin
        frame_data <= data_in;
        frame_mark <= mark_in;
      end
    end
  end

  assign locked    = (state == ST_LOCKED);
  assign moving    = (state != ST_IDLE);
  assign dbg.state = state;
  assign dbg.lc    = lc;

endmodule

// File: tb/tb_tc08_line_decoder.sv
// Bench for tc08_line_decoder: drives TU55-style head waveforms, scoreboards frames
// against hand-derived values and checks lock, error, watchdog and reset behaviour.
module tb_tc08_line_decoder;
  import tc08_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 300;
  localparam int LINE_CLKS   = 40;
  localparam int HALF        = LINE_CLKS / 2;

  localparam logic [5:0]  M25      = 6'o25;
  localparam logic [5:0]  M26      = 6'o26;
  localparam logic [5:0]  M77      = 6'o77;
  localparam logic [17:0] FWD_DATA = 18'o712345;
  localparam logic [17:0] REV_DATA = 18'o065432;

  // clock / reset
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic t_pos = 1'b0, t_neg = 1'b0, mk_pos = 1'b0, mk_neg = 1'b0;
  logic d0_pos = 1'b0, d0_neg = 1'b0, d1_pos = 1'b0, d1_neg = 1'b0;
  logic d2_pos = 1'b0, d2_neg = 1'b0;

  logic        line_strobe, frame_strobe, locked, mark_err, moving;
  logic [17:0] frame_data;
  logic [5:0]  frame_mark;
  tc08_dbg_t   dbg;

  tc08_line_decoder #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_l(rst_l),
    .t_trk_rd_pos(t_pos), .t_trk_rd_neg(t_neg),
    .rdmk_rd_pos(mk_pos), .rdmk_rd_neg(mk_neg),
    .rdd_00_rd_pos(d0_pos), .rdd_00_rd_neg(d0_neg),
    .rdd_01_rd_pos(d1_pos), .rdd_01_rd_neg(d1_neg),
    .rdd_02_rd_pos(d2_pos), .rdd_02_rd_neg(d2_neg),
    .line_strobe(line_strobe), .frame_strobe(frame_strobe),
    .frame_data(frame_data), .frame_mark(frame_mark),
    .locked(locked), .mark_err(mark_err), .moving(moving), .dbg(dbg)
  );

  // scoreboard
  logic [23:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int ls_cnt  = 0;
  int last_ls_cyc = 0;
  logic [2:0] line_dat [0:5] = '{3'o7, 3'o1, 3'o2, 3'o3, 3'o4, 3'o5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (line_strobe) begin
      ls_cnt++;
      last_ls_cyc = cyc;
    end
    if (frame_strobe) begin
      check("frame_with_line", 32'(line_strobe), 32'd1);
      if (exp_q.size() == 0) begin
        check("frame_unexpected", 32'(frame_strobe), 32'd0);
      end else begin
        check("frame", 32'({frame_mark, frame_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic push_frame(input logic [5:0] mk, input logic [17:0] data);
    exp_q.push_back({mk, data});
  endtask

  task automatic stop_tape();
    t_pos = 1'b0;
    t_neg = 1'b0;
  endtask

  task automatic line_start(input logic mk, input logic [2:0] d, input logic rev);
    logic [2:0] dv;
    dv = rev ? ~d : d;
    t_pos  = !rev;  t_neg  = rev;
    mk_pos = mk;    mk_neg = !mk;
    d0_pos = dv[2]; d0_neg = !dv[2];
    d1_pos = dv[1]; d1_neg = !dv[1];
    d2_pos = dv[0]; d2_neg = !dv[0];
  endtask

  task automatic line_finish(input int first);
    repeat (first) @(negedge clk);
    t_pos = !t_pos;
    t_neg = !t_neg;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [5:0] mk, input logic rev, input int first_line);
    for (int i = first_line; i < 6; i++) begin
      line_start(mk[5-i], line_dat[i], rev);
      line_finish(HALF);
    end
  endtask

  task automatic wait_stall(output int dt);
    for (int i = 0; i < TIMEOUT + 100; i++) begin
      @(negedge clk);
      if (!moving) break;
    end
    check("stall_seen", 32'(moving), 32'd0);
    dt = cyc - last_ls_cyc;
  endtask

  task automatic chk_cleared(input string tag);
    check({tag, "_line_strobe"},  32'(line_strobe),  32'd0);
    check({tag, "_frame_strobe"}, 32'(frame_strobe), 32'd0);
    check({tag, "_frame_data"},   32'(frame_data),   32'd0);
    check({tag, "_frame_mark"},   32'(frame_mark),   32'd0);
    check({tag, "_locked"},       32'(locked),       32'd0);
    check({tag, "_mark_err"},     32'(mark_err),     32'd0);
    check({tag, "_moving"},       32'(moving),       32'd0);
    check({tag, "_state"},        32'(dbg.state),    32'(ST_IDLE));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int dt;
    int c0;
    // reset held with toggling inputs
    rst_l = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      t_pos  = 1'($urandom_range(0, 1)); t_neg  = 1'($urandom_range(0, 1));
      mk_pos = 1'($urandom_range(0, 1)); mk_neg = 1'($urandom_range(0, 1));
      d0_pos = 1'($urandom_range(0, 1)); d0_neg = 1'($urandom_range(0, 1));
      d1_pos = 1'($urandom_range(0, 1)); d1_neg = 1'($urandom_range(0, 1));
      d2_pos = 1'($urandom_range(0, 1)); d2_neg = 1'($urandom_range(0, 1));
    end
    chk_cleared("reset");
    check("reset_no_lines", 32'(ls_cnt), 32'd0);
    stop_tape();
    @(negedge clk);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);

    // forward acquisition: one sync frame then four block frames
    push_frame(M25, FWD_DATA);
    send_frame(M25, 1'b0, 0);
    check("acq_locked", 32'(locked), 32'd1);
    for (int f = 0; f < 4; f++) begin
      push_frame(M26, FWD_DATA);
      send_frame(M26, 1'b0, 0);
    end
    check("fwd_lines", 32'(ls_cnt), 32'd30);
    check("fwd_locked", 32'(locked), 32'd1);
    check("fwd_moving", 32'(moving), 32'd1);
    check("fwd_err", 32'(mark_err), 32'd0);
    check("fwd_q_empty", 32'(exp_q.size()), 32'd0);

    // invalid mark window while locked, then re-acquire
    send_frame(M77, 1'b0, 0);
    check("bad_mark_err", 32'(mark_err), 32'd1);
    check("bad_mark_locked", 32'(locked), 32'd0);
    check("bad_mark_state", 32'(dbg.state), 32'(ST_HUNT));
    push_frame(M25, FWD_DATA);
    send_frame(M25, 1'b0, 0);
    check("reacq_locked", 32'(locked), 32'd1);
    check("reacq_err", 32'(mark_err), 32'd0);
    push_frame(M26, FWD_DATA);
    send_frame(M26, 1'b0, 0);

    // line edge lands on the watchdog's final clock: edge wins
    stop_tape();
    c0 = last_ls_cyc;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (cyc == c0 + TIMEOUT - 3) break;
      @(negedge clk);
    end
    check("edge_align", 32'(cyc - c0), 32'(TIMEOUT - 3));
    push_frame(M26, FWD_DATA);
    line_start(M26[5], line_dat[0], 1'b0);
    repeat (3) @(negedge clk);
    check("edge_latency", 32'(line_strobe), 32'd1);
    check("edge_clk", 32'(cyc - c0), 32'(TIMEOUT));
    check("edge_moving", 32'(moving), 32'd1);
    line_finish(HALF - 3);
    send_frame(M26, 1'b0, 1);
    check("edge_locked", 32'(locked), 32'd1);

    // timing stops: exact watchdog expiry
    stop_tape();
    wait_stall(dt);
    check("stall_clk", 32'(dt), 32'(TIMEOUT));
    check("stall_locked", 32'(locked), 32'd0);
    check("stall_state", 32'(dbg.state), 32'(ST_IDLE));
    check("stall_hold", 32'({frame_mark, frame_data}), 32'({M26, FWD_DATA}));

    // reverse motion: phases swapped, data complemented
    ls_cnt = 0;
    push_frame(M25, REV_DATA);
    send_frame(M25, 1'b1, 0);
    for (int f = 0; f < 2; f++) begin
      push_frame(M26, REV_DATA);
      send_frame(M26, 1'b1, 0);
    end
    check("rev_lines", 32'(ls_cnt), 32'd18);
    check("rev_locked", 32'(locked), 32'd1);
    check("rev_q_empty", 32'(exp_q.size()), 32'd0);
    stop_tape();
    wait_stall(dt);

    // reset mid-frame at lc=3
    push_frame(M25, FWD_DATA);
    send_frame(M25, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      line_start(M26[5-i], line_dat[i], 1'b0);
      line_finish(HALF);
    end
    check("mid_lc", 32'(dbg.lc), 32'd3);
    check("mid_locked", 32'(locked), 32'd1);
    #2 rst_l = 1'b0;
    #1 chk_cleared("mid_reset");
    repeat (4) @(negedge clk);
    rst_l = 1'b1;
    send_frame(M26, 1'b0, 3);
    send_frame(M26, 1'b0, 0);
    check("post_rst_locked", 32'(locked), 32'd0);
    push_frame(M25, FWD_DATA);
    send_frame(M25, 1'b0, 0);
    push_frame(M26, FWD_DATA);
    send_frame(M26, 1'b0, 0);
    check("post_rst_relock", 32'(locked), 32'd1);

    repeat (5) @(negedge clk);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
